// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine: finds which LFSR tap pattern encrypted a memory block
// from its known preamble, then writes the decrypted block back to memory.
// Optional build macro: PREAMBLE_STRIP_EN (drop leading preamble, pad tail).
module lfsr_decrypt_engine #(
    parameter int                   DW       = 8,
    parameter int                   LW       = 6,
    parameter int                   AW       = 8,
    parameter int                   NTAP     = 6,
    parameter logic [NTAP*LW-1:0]   TAPS     = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
    parameter logic [DW-1:0]        PRE_CHAR = 8'h5F,
    parameter int                   PRE_LEN  = 7,
    parameter int                   MSG_LEN  = 64,
    parameter int                   RD_BASE  = 64,
    parameter int                   WR_BASE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ambig,
    output logic [$clog2(NTAP)-1:0] tap_sel,
    output logic [AW-1:0]           raddr,
    input  logic [DW-1:0]           rdata,
    output logic [AW-1:0]           waddr,
    output logic [DW-1:0]           wdata,
    output logic                    wr_en
);

    localparam int              TSW        = $clog2(NTAP);
    localparam int              CW         = $clog2(MSG_LEN + 1);
    localparam logic [LW-1:0]   PRE_L      = PRE_CHAR[LW-1:0];
    localparam logic [AW-1:0]   RB         = AW'(RD_BASE);
    localparam logic [AW-1:0]   WB         = AW'(WR_BASE);
    localparam logic [CW-1:0]   TRAIN_LAST = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0]   RUN_LAST   = CW'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_TRAIN = 3'd2,
        S_LOAD  = 3'd3,
        S_RUN   = 3'd4,
`ifdef PREAMBLE_STRIP_EN
        S_PAD   = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_t;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s,
                                                input logic [LW-1:0] t);
        return {s[LW-2:0], ^(s & t)};
    endfunction

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [LW-1:0]            seed_q, seed_d;
    logic [NTAP-1:0][LW-1:0]  trial_q, trial_d;
    logic [NTAP-1:0]          alive_q, alive_d;
    logic [LW-1:0]            dec_q, dec_d;
    logic [LW-1:0]            dtap_q, dtap_d;
    logic [TSW-1:0]           tsel_q, tsel_d;
    logic                     err_q, err_d;
    logic                     ambig_q, ambig_d;
`ifdef PREAMBLE_STRIP_EN
    logic [CW-1:0]            wptr_q, wptr_d;
    logic                     strip_q, strip_d;
    logic                     keep;
`endif

    logic [NTAP-1:0][LW-1:0]  trial_nx;
    logic [NTAP-1:0]          train_ok;
    logic [TSW-1:0]           first;
    logic                     multi;
    logic [LW-1:0]            key_in;
    logic [DW-1:0]            plain;

    assign key_in = PRE_L ^ rdata[LW-1:0];
    assign plain  = rdata ^ DW'(dec_q);
`ifdef PREAMBLE_STRIP_EN
    assign keep   = !(strip_q && plain == PRE_CHAR);
`endif

    // Step every trial LFSR and pick the surviving patterns
    always_comb begin
        trial_nx = trial_q;
        train_ok = '0;
        first    = '0;
        for (int i = 0; i < NTAP; i++) begin
            trial_nx[i] = lfsr_step(trial_q[i], TAPS[i*LW +: LW]);
            train_ok[i] = alive_q[i] && (trial_nx[i] == key_in);
        end
        for (int i = NTAP - 1; i >= 0; i--) begin
            if (train_ok[i]) first = TSW'(i);
        end
        multi = (train_ok & (train_ok - 1'b1)) != '0;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            trial_q <= '0;
            alive_q <= '0;
            dec_q   <= '0;
            dtap_q  <= '0;
            tsel_q  <= '0;
            err_q   <= 1'b0;
            ambig_q <= 1'b0;
`ifdef PREAMBLE_STRIP_EN
            wptr_q  <= '0;
            strip_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            trial_q <= trial_d;
            alive_q <= alive_d;
            dec_q   <= dec_d;
            dtap_q  <= dtap_d;
            tsel_q  <= tsel_d;
            err_q   <= err_d;
            ambig_q <= ambig_d;
`ifdef PREAMBLE_STRIP_EN
            wptr_q  <= wptr_d;
            strip_q <= strip_d;
`endif
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        trial_d = trial_q;
        alive_d = alive_q;
        dec_d   = dec_q;
        dtap_d  = dtap_q;
        tsel_d  = tsel_q;
        err_d   = err_q;
        ambig_d = ambig_q;
`ifdef PREAMBLE_STRIP_EN
        wptr_d  = wptr_q;
        strip_d = strip_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (init) begin
                    state_d = S_SEED;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    ambig_d = 1'b0;
                end
            end
            S_SEED: begin
                seed_d  = key_in;
                trial_d = {NTAP{key_in}};
                alive_d = '1;
                cnt_d   = CW'(1);
                state_d = S_TRAIN;
            end
            S_TRAIN: begin
                trial_d = trial_nx;
                alive_d = train_ok;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == TRAIN_LAST) begin
                    cnt_d = '0;
                    // a zero seed locks every LFSR at zero; never trust it
                    if (train_ok == '0 || seed_q == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tsel_d  = first;
                        ambig_d = multi;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                dec_d   = seed_q;
                dtap_d  = TAPS[tsel_q*LW +: LW];
                cnt_d   = '0;
                state_d = S_RUN;
`ifdef PREAMBLE_STRIP_EN
                wptr_d  = '0;
                strip_d = 1'b1;
`endif
            end
            S_RUN: begin
                dec_d = lfsr_step(dec_q, dtap_q);
                cnt_d = cnt_q + 1'b1;
`ifdef PREAMBLE_STRIP_EN
                if (keep) begin
                    strip_d = 1'b0;
                    wptr_d  = wptr_q + 1'b1;
                end
                if (cnt_q == RUN_LAST) begin
                    state_d = (wptr_d == CW'(MSG_LEN)) ? S_DONE : S_PAD;
                end
`else
                if (cnt_q == RUN_LAST) state_d = S_DONE;
`endif
            end
`ifdef PREAMBLE_STRIP_EN
            S_PAD: begin
                wptr_d = wptr_q + 1'b1;
                if (wptr_q == RUN_LAST) state_d = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side and status outputs decoded from state and counters
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        wr_en = 1'b0;
        unique case (state_q)
            S_SEED, S_TRAIN: begin
                busy  = 1'b1;
                raddr = RB + AW'(cnt_q);
            end
            S_LOAD: busy = 1'b1;
            S_RUN: begin
                busy  = 1'b1;
                raddr = RB + AW'(cnt_q);
`ifdef PREAMBLE_STRIP_EN
                if (keep) begin
                    wr_en = 1'b1;
                    waddr = WB + AW'(wptr_q);
                    wdata = plain;
                end
`else
                wr_en = 1'b1;
                waddr = WB + AW'(cnt_q);
                wdata = plain;
`endif
            end
`ifdef PREAMBLE_STRIP_EN
            S_PAD: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                waddr = WB + AW'(wptr_q);
                wdata = DW'(8'h20);
            end
`endif
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign err     = err_q;
    assign ambig   = ambig_q;
    assign tap_sel = tsel_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb_lfsr_decrypt_engine: randomized scoreboard bench for lfsr_decrypt_engine.
// A second instance with a two-byte preamble exercises pattern ambiguity.
module tb_lfsr_decrypt_engine;

    localparam int MSG = 64;
    localparam int RDB = 64;
    localparam int WRB = 0;
    localparam logic [35:0] TAPS_P = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21};

    typedef struct {
        bit b;
        bit err;
        bit amb;
        int sel;
        int cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_a = 1'b0, init_b = 1'b0;
    logic busy_a, done_a, err_a, ambig_a, wr_a;
    logic busy_b, done_b, err_b, ambig_b, wr_b;
    logic [2:0] tsel_a, tsel_b;
    logic [7:0] raddr_a, rdata_a, waddr_a, wdata_a;
    logic [7:0] raddr_b, rdata_b, waddr_b, wdata_b;
    logic [7:0] src [256];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_amb = 0;
    logic [15:0] exp_wq [$];
    res_t res_q [$];
    logic dprev_a = 1'b0, dprev_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata_a = src[raddr_a];
    assign rdata_b = src[raddr_b];

    lfsr_decrypt_engine u_dut (
        .clk(clk), .rst_n(rst_n), .init(init_a),
        .busy(busy_a), .done(done_a), .err(err_a), .ambig(ambig_a),
        .tap_sel(tsel_a), .raddr(raddr_a), .rdata(rdata_a),
        .waddr(waddr_a), .wdata(wdata_a), .wr_en(wr_a)
    );

    lfsr_decrypt_engine #(.PRE_LEN(2)) u_amb (
        .clk(clk), .rst_n(rst_n), .init(init_b),
        .busy(busy_b), .done(done_b), .err(err_b), .ambig(ambig_b),
        .tap_sel(tsel_b), .raddr(raddr_b), .rdata(rdata_b),
        .waddr(waddr_b), .wdata(wdata_b), .wr_en(wr_b)
    );

    // next key: shift left, append parity of tapped bits
    function automatic logic [5:0] nxt(input logic [5:0] s, input logic [5:0] t);
        int v;
        v = int'(s) * 2 + ($countones(s & t) % 2);
        return 6'(v % 64);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic gen_block(input logic [5:0] seed, input int pat, input int nlead);
        string msg;
        logic [35:0] tv;
        logic [5:0] key, t;
        logic [7:0] pl;
        msg = "Mr. Watson, come here";
        tv = TAPS_P;
        t = tv[pat*6 +: 6];
        key = seed;
        for (int k = 0; k < MSG; k++) begin
            if (k < nlead) pl = 8'h5F;
            else if (k - nlead < msg.len()) pl = msg[k - nlead];
            else pl = 8'($urandom_range(32, 126));
            src[RDB + k] = pl ^ {2'b00, key};
            key = nxt(key, t);
        end
    endtask

    task automatic predict(input bit b, input int pl, input int stop_k,
                           input bit full, input int e0);
        logic [35:0] tv;
        logic [5:0] seed, key, t, alive;
        logic [7:0] p;
        int sel, wp;
        res_t r;
`ifdef PREAMBLE_STRIP_EN
        bit strip;
`endif
        tv = TAPS_P;
        seed = src[RDB][5:0] ^ 6'h1F;
        alive = '0;
        sel = 0;
        for (int i = 0; i < 6; i++) begin
            t = tv[i*6 +: 6];
            key = seed;
            alive[i] = (seed != 0);
            for (int j = 1; j < pl; j++) begin
                key = nxt(key, t);
                if (key != (src[RDB + j][5:0] ^ 6'h1F)) alive[i] = 1'b0;
            end
        end
        for (int i = 5; i >= 0; i--) if (alive[i]) sel = i;
        r.b = b;
        r.err = (alive == 0);
        r.amb = ($countones(alive) > 1);
        r.sel = sel;
        if (r.amb) n_amb++;
        wp = 0;
        if (!r.err) begin
            key = seed;
            t = tv[sel*6 +: 6];
`ifdef PREAMBLE_STRIP_EN
            strip = 1'b1;
`endif
            for (int k = 0; k < MSG; k++) begin
                p = src[RDB + k] ^ {2'b00, key};
                key = nxt(key, t);
`ifdef PREAMBLE_STRIP_EN
                if (strip && p == 8'h5F) continue;
                strip = 1'b0;
`endif
                if (k <= stop_k) exp_wq.push_back({8'(WRB + wp), p});
                wp++;
            end
            r.cyc = e0 + pl + 1 + MSG + (MSG - wp);
            if (full) begin
                while (wp < MSG) begin
                    exp_wq.push_back({8'(WRB + wp), 8'h20});
                    wp++;
                end
            end
        end else begin
            r.cyc = e0 + pl;
        end
        if (full) res_q.push_back(r);
    endtask

    task automatic check_res(input bit b, input bit e, input bit a, input logic [2:0] s);
        res_t r;
        vectors++;
        if (res_q.size() == 0) begin
            miscompares++;
            $display("FAIL done: unexpected done on dut%0d at cycle %0d", b, cyc);
            return;
        end
        r = res_q.pop_front();
        chk("done_source", int'(b), int'(r.b));
        chk("err", int'(e), int'(r.err));
        chk("done_latency", cyc, r.cyc);
        if (!r.err) begin
            chk("ambig", int'(a), int'(r.amb));
            chk("tap_sel", int'(s), r.sel);
        end
    endtask

    // scoreboard monitor: every write and every done edge is matched in order
    always @(negedge clk) begin
        logic [15:0] got, e;
        if (wr_a || wr_b) begin
            got = wr_a ? {waddr_a, wdata_a} : {waddr_b, wdata_b};
            vectors++;
            if (exp_wq.size() == 0) begin
                miscompares++;
                $display("FAIL write: unexpected addr %h data %h", got[15:8], got[7:0]);
            end else begin
                e = exp_wq.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             got[15:8], got[7:0], e[15:8], e[7:0]);
                end
            end
        end
        if (done_a && !dprev_a) check_res(1'b0, err_a, ambig_a, tsel_a);
        if (done_b && !dprev_b) check_res(1'b1, err_b, ambig_b, tsel_b);
        dprev_a <= done_a;
        dprev_b <= done_b;
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, int'(busy_a), 0);
        chk({nm, "_done"}, int'(done_a), 0);
        chk({nm, "_err"}, int'(err_a), 0);
        chk({nm, "_ambig"}, int'(ambig_a), 0);
        chk({nm, "_tap_sel"}, int'(tsel_a), 0);
        chk({nm, "_raddr"}, int'(raddr_a), 0);
        chk({nm, "_waddr"}, int'(waddr_a), 0);
        chk({nm, "_wdata"}, int'(wdata_a), 0);
        chk({nm, "_wr_en"}, int'(wr_a), 0);
    endtask

    task automatic run(input bit b, input int pl, input int pulse_k, input int rst_k);
        int e0;
        bit seen, pulse;
        seen = 1'b0;
        @(negedge clk);
        e0 = cyc + 1;
        predict(b, pl, (rst_k >= 0) ? rst_k : MSG, rst_k < 0, e0);
        if (b) init_b = 1'b1;
        else init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        init_b = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (rst_k >= 0 && cyc == e0 + 8 + rst_k) begin
                #1 rst_n = 1'b0;
                #1 chk_zero("midrun_reset");
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                seen = 1'b1;
                break;
            end
            pulse = (pulse_k >= 0 && cyc == e0 + 8 + pulse_k);
            if (b) init_b = pulse;
            else init_a = pulse;
            if (b ? done_b : done_a) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        init_a = 1'b0;
        init_b = 1'b0;
        @(negedge clk);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL timeout: dut%0d never reached done", b);
        end
        chk("leftover_writes", exp_wq.size(), 0);
        chk("leftover_results", res_q.size(), 0);
        exp_wq.delete();
        res_q.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");

        // golden message, pattern 1, seed 1
        gen_block(6'h01, 1, 7);
        run(1'b0, 7, -1, -1);
        repeat (3) @(negedge clk);
        chk("done_hold", int'(done_a), 1);
        chk("t1_tap_sel", int'(tsel_a), 1);

        // every pattern with random non-zero seeds
        for (int p = 0; p < 6; p++) begin
            for (int r = 0; r < 20; r++) begin
                gen_block(6'($urandom_range(1, 63)), p, 7 + $urandom_range(0, 3));
                run(1'b0, 7, -1, -1);
            end
        end

        // zero seed lockup
        gen_block(6'h00, 0, 7);
        run(1'b0, 7, -1, -1);
        chk("t3_err", int'(err_a), 1);

        // two-byte preamble: ambiguity and lowest index
        n_amb = 0;
        for (int r = 0; r < 40 && (r < 8 || n_amb < 2); r++) begin
            gen_block(6'($urandom_range(1, 63)), $urandom_range(0, 5), 7);
            run(1'b1, 2, -1, -1);
        end
        vectors++;
        if (n_amb == 0) begin
            miscompares++;
            $display("FAIL ambig_cover: no ambiguous run generated");
        end

        // init mid-run is ignored; reset mid-run stops writes; then recover
        gen_block(6'($urandom_range(1, 63)), 3, 7);
        run(1'b0, 7, 20, -1);
        gen_block(6'($urandom_range(1, 63)), 4, 7);
        run(1'b0, 7, -1, 30);
        repeat (2) @(negedge clk);
        chk_zero("post_reset_idle");
        gen_block(6'($urandom_range(1, 63)), 2, 10);
        run(1'b0, 7, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
